// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch record for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] inst;
  } fetch_entry_t;

  localparam logic [DATA_W_DEF-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear; head entry is read straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_next(wptr_q);
      if (do_pop)  rptr_d = ptr_next(rptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited memory requests, in-order responses, PC tagging,
// decode-side buffer and flush via a kill counter that drops stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(MAX_OUTST+1);
  localparam int unsigned BW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [CW-1:0]     outst_q, outst_d, kill_q, kill_d;
  logic [CW-1:0]     pcq_count;
  logic [BW-1:0]     buf_count;
  logic [ADDR_W-1:0] pcq_head;
  entry_t            buf_wdata, buf_rdata;
  logic [31:0]       inflight;
  logic              accept, rsp_ok, deliver, pop;

  // Stale (killed) responses no longer need buffer space, so they leave the credit.
  always_comb begin
    inflight       = 32'(outst_q) - 32'(kill_q) + 32'(buf_count);
    imem_req_valid = reset && !flush && (inflight < 32'(DEPTH))
                     && (32'(outst_q) < 32'(MAX_OUTST));
  end

  assign imem_req_addr = {pc[ADDR_W-1:2], 2'b00};
  assign pc_advance    = imem_req_valid && imem_req_ready;
  assign accept        = pc_advance;
  assign rsp_ok        = imem_rsp_valid && (outst_q != '0);
  assign deliver       = rsp_ok && !flush && (kill_q == '0);
  assign pop           = inst_valid && inst_ready;

  always_comb begin
    outst_d = outst_q;
    if (accept && !rsp_ok)      outst_d = outst_q + 1'b1;
    else if (rsp_ok && !accept) outst_d = outst_q - 1'b1;

    kill_d = kill_q;
    if (flush)                       kill_d = rsp_ok ? outst_q - 1'b1 : outst_q;
    else if (rsp_ok && kill_q != '0) kill_d = kill_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outst_q <= '0;
      kill_q  <= '0;
    end else begin
      outst_q <= outst_d;
      kill_q  <= kill_d;
    end
  end

  assign buf_wdata = '{pc: pcq_head, inst: imem_rsp_data};

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_pc_queue (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (flush),
    .push_i  (accept),
    .wdata_i (imem_req_addr),
    .pop_i   (deliver),
    .rdata_o (pcq_head),
    .count_o (pcq_count)
  );

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (flush),
    .push_i  (deliver),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  assign inst_valid = (buf_count != '0);
  assign inst_data  = buf_rdata.inst;
  assign inst_pc    = buf_rdata.pc;

  a_rsp_expected: assert property (@(posedge clock) disable iff (!reset)
    imem_rsp_valid |-> (outst_q != '0));
  a_pcq_tracks_live: assert property (@(posedge clock) disable iff (!reset)
    32'(pcq_count) == 32'(outst_q) - 32'(kill_q));

endmodule
